// File: rtl/dispenser_pkg.sv
// Shared types for the drink dispenser: FSM states, drink codes and the recipe table.
// Durations are expressed in dispense ticks; a step with zero ticks is never entered.
package dispenser_pkg;

   localparam int MAX_TICKS = 4;
   typedef logic [$clog2(MAX_TICKS+1)-1:0] ticks_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SUGAR  = 3'd1,
      ST_COFFEE = 3'd2,
      ST_WATER  = 3'd3,
      ST_MILK   = 3'd4,
      ST_CHOCO  = 3'd5,
      ST_READY  = 3'd6
   } state_e;

   localparam logic [2:0] DRINK_ESPRESSO   = 3'd0;
   localparam logic [2:0] DRINK_AMERICANO  = 3'd1;
   localparam logic [2:0] DRINK_LATTE      = 3'd2;
   localparam logic [2:0] DRINK_CAPPUCCINO = 3'd3;
   localparam logic [2:0] DRINK_MOCACCINO  = 3'd4;

   localparam ticks_t SUGAR_TICKS = 3'd1;

   typedef struct packed {
      ticks_t cafe;
      ticks_t agua;
      ticks_t leche;
      ticks_t choco;
   } recipe_t;

   function automatic recipe_t recipe(input logic [2:0] drink);
      recipe_t r;
      r = '0;
      case (drink)
         DRINK_ESPRESSO:   r = '{cafe: 3'd2, agua: 3'd1, leche: 3'd0, choco: 3'd0};
         DRINK_AMERICANO:  r = '{cafe: 3'd2, agua: 3'd4, leche: 3'd0, choco: 3'd0};
         DRINK_LATTE:      r = '{cafe: 3'd2, agua: 3'd0, leche: 3'd4, choco: 3'd0};
         DRINK_CAPPUCCINO: r = '{cafe: 3'd2, agua: 3'd1, leche: 3'd3, choco: 3'd0};
         DRINK_MOCACCINO:  r = '{cafe: 3'd2, agua: 3'd0, leche: 3'd2, choco: 3'd2};
         default:          r = '0;
      endcase
      return r;
   endfunction

   function automatic logic drink_valid(input logic [2:0] drink);
      return drink <= DRINK_MOCACCINO;
   endfunction

   // Bit i set means step state (i+1) has work to do.
   function automatic logic [4:0] step_mask(input recipe_t r, input logic sug);
      return {r.choco != 3'd0, r.leche != 3'd0, r.agua != 3'd0, r.cafe != 3'd0, sug};
   endfunction

   function automatic state_e next_step(input state_e cur, input logic [4:0] mask);
      state_e nxt;
      nxt = ST_READY;
      for (int i = 4; i >= 0; i--) begin
         if (mask[i] && (i + 1) > int'(cur)) nxt = state_e'(3'(i + 1));
      end
      return nxt;
   endfunction

   function automatic ticks_t step_ticks(input state_e s, input recipe_t r);
      ticks_t t;
      case (s)
         ST_SUGAR:  t = SUGAR_TICKS;
         ST_COFFEE: t = r.cafe;
         ST_WATER:  t = r.agua;
         ST_MILK:   t = r.leche;
         ST_CHOCO:  t = r.choco;
         default:   t = '0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Dispense-tick prescaler: counts 0..TICK_DIV-1 and flags the last count as a tick.
// Tick is a function of the count register only; clr restarts the count on the next edge.
module tick_gen #(
   parameter int TICK_DIV = 50_000
) (
   input  logic clk_50Mhz,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr || cnt_q == LAST) cnt_d = '0;
   end

   always_ff @(posedge clk_50Mhz or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/dispenser_sequencer.sv
// Drink dispenser sequencer: walks the recipe steps, driving one valve per step for duration*TICK_DIV cycles.
// First valve rises the cycle after start; outputs are flops so reset drops them without a clock edge.
module dispenser_sequencer
   import dispenser_pkg::*;
#(
   parameter int TICK_DIV = 50_000
) (
   input  logic       clk_50Mhz,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] drink,
   input  logic       sugar,
   input  logic       abort,
   input  logic       retirar,
   output logic       agua,
   output logic       cafe,
   output logic       leche,
   output logic       choco,
   output logic       azucar,
   output logic       busy,
   output logic       bebida_lista,
   output logic       error
);

   state_e     state_q, state_d;
   logic [2:0] drink_q, drink_d;
   logic       sugar_q, sugar_d;
   ticks_t     tick_cnt_q, tick_cnt_d;
   logic       error_d;
   logic       clr, tick;
   recipe_t    rec_in, rec_q;
   logic [4:0] valves_q, valves_d;
   logic       busy_q, lista_q, error_q;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk_50Mhz (clk_50Mhz),
      .rst       (rst),
      .clr       (clr),
      .tick      (tick)
   );

   always_comb begin
      state_d = state_q;
      drink_d = drink_q;
      sugar_d = sugar_q;
      error_d = 1'b0;
      rec_in  = recipe(drink);
      rec_q   = recipe(drink_q);
      case (state_q)
         ST_IDLE: begin
            // Start wins over a simultaneous abort; abort is re-evaluated in the first step.
            if (start) begin
               if (drink_valid(drink)) begin
                  drink_d = drink;
                  sugar_d = sugar;
                  state_d = next_step(ST_IDLE, step_mask(rec_in, sugar));
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         ST_READY: if (retirar) state_d = ST_IDLE;
         default: begin
            if (abort) state_d = ST_IDLE;
            else if (tick && tick_cnt_q == step_ticks(state_q, rec_q) - 3'd1)
               state_d = next_step(state_q, step_mask(rec_q, sugar_q));
         end
      endcase

      clr = (state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_READY);
      tick_cnt_d = tick_cnt_q;
      if (clr)       tick_cnt_d = '0;
      else if (tick) tick_cnt_d = tick_cnt_q + 1'b1;

      valves_d = '0;
      case (state_d)
         ST_SUGAR:  valves_d[4] = 1'b1;
         ST_COFFEE: valves_d[0] = 1'b1;
         ST_WATER:  valves_d[1] = 1'b1;
         ST_MILK:   valves_d[2] = 1'b1;
         ST_CHOCO:  valves_d[3] = 1'b1;
         default:   valves_d = '0;
      endcase
   end

   always_ff @(posedge clk_50Mhz or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         drink_q    <= '0;
         sugar_q    <= 1'b0;
         tick_cnt_q <= '0;
         valves_q   <= '0;
         busy_q     <= 1'b0;
         lista_q    <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         drink_q    <= drink_d;
         sugar_q    <= sugar_d;
         tick_cnt_q <= tick_cnt_d;
         valves_q   <= valves_d;
         busy_q     <= (state_d != ST_IDLE);
         lista_q    <= (state_d == ST_READY);
         error_q    <= error_d;
      end
   end

   assign cafe         = valves_q[0];
   assign agua         = valves_q[1];
   assign leche        = valves_q[2];
   assign choco        = valves_q[3];
   assign azucar       = valves_q[4];
   assign busy         = busy_q;
   assign bebida_lista = lista_q;
   assign error        = error_q;

endmodule

// File: tb/tb_dispenser_sequencer.sv
// Directed bench for dispenser_sequencer: expected output runs are queued by the stimulus
// and a negedge monitor compares each completed run (output pattern, length, back-to-back flag).
module tb_dispenser_sequencer;

   localparam int TD = 4;

   logic       clk_50Mhz = 1'b0;
   logic       rst       = 1'b1;
   logic       start     = 1'b0;
   logic [2:0] drink     = 3'd0;
   logic       sugar     = 1'b0;
   logic       abort     = 1'b0;
   logic       retirar   = 1'b0;
   logic       agua, cafe, leche, choco, azucar, busy, bebida_lista, error;

   dispenser_sequencer #(.TICK_DIV(TD)) dut (
      .clk_50Mhz    (clk_50Mhz),
      .rst          (rst),
      .start        (start),
      .drink        (drink),
      .sugar        (sugar),
      .abort        (abort),
      .retirar      (retirar),
      .agua         (agua),
      .cafe         (cafe),
      .leche        (leche),
      .choco        (choco),
      .azucar       (azucar),
      .busy         (busy),
      .bebida_lista (bebida_lista),
      .error        (error)
   );

   always #5 clk_50Mhz = ~clk_50Mhz;

   // Output vector layout: {error, bebida_lista, busy, azucar, choco, leche, agua, cafe}
   localparam logic [7:0] V_IDLE  = 8'h00;
   localparam logic [7:0] V_AZ    = 8'h30;
   localparam logic [7:0] V_CHOCO = 8'h28;
   localparam logic [7:0] V_LECHE = 8'h24;
   localparam logic [7:0] V_AGUA  = 8'h22;
   localparam logic [7:0] V_CAFE  = 8'h21;
   localparam logic [7:0] V_LISTA = 8'h60;
   localparam logic [7:0] V_ERR   = 8'h80;

   typedef struct {
      logic [7:0] vec;
      int         len;
      bit         chained;
   } run_t;

   run_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   function automatic logic [7:0] outv();
      return {error, bebida_lista, busy, azucar, choco, leche, agua, cafe};
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic expect_run(input logic [7:0] v, input int len, input bit ch);
      run_t r;
      r.vec = v;
      r.len = len;
      r.chained = ch;
      exp_q.push_back(r);
   endtask

   // Caller is positioned at a negedge; returns at the negedge of cycle 1 after the start edge.
   task automatic issue_start(input logic [2:0] d, input logic s);
      start = 1'b1;
      drink = d;
      sugar = s;
      @(negedge clk_50Mhz);
      start = 1'b0;
   endtask

   logic [7:0] cur_v = 8'h00;
   int         cur_len = 0;
   bit         cur_chain = 1'b0;

   always @(negedge clk_50Mhz) begin : monitor
      logic [7:0] v;
      run_t e;
      v = outv();
      n_checks++;
      if ($countones(v[4:0]) <= 1) n_pass++;
      else $display("FAIL onehot: valves {azucar,choco,leche,agua,cafe} = %b", v[4:0]);
      if (v !== cur_v) begin
         if (cur_v != 8'h00) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL run: unexpected output %h for %0d cycles", cur_v, cur_len);
            end else begin
               e = exp_q.pop_front();
               if (e.vec === cur_v && e.len == cur_len && e.chained == cur_chain) n_pass++;
               else $display("FAIL run: got %h x%0d chained=%0d, expected %h x%0d chained=%0d",
                             cur_v, cur_len, cur_chain, e.vec, e.len, e.chained);
            end
         end
         cur_chain = (cur_v != 8'h00);
         cur_v     = v;
         cur_len   = 1;
      end else begin
         cur_len++;
      end
   end

   initial begin
      #1 rst = 1'b0;
      @(negedge clk_50Mhz);
      check("reset_state", outv(), V_IDLE);
      @(negedge clk_50Mhz);
      rst = 1'b1;
      @(negedge clk_50Mhz);

      // Mocaccino with sugar
      expect_run(V_AZ, 4, 1'b0);
      expect_run(V_CAFE, 8, 1'b1);
      expect_run(V_LECHE, 8, 1'b1);
      expect_run(V_CHOCO, 8, 1'b1);
      expect_run(V_LISTA, 3, 1'b1);
      issue_start(3'd4, 1'b1);
      check("moca_first_valve", outv(), V_AZ);
      repeat (27) @(negedge clk_50Mhz);
      check("moca_c28_choco", outv(), V_CHOCO);
      @(negedge clk_50Mhz);
      check("moca_c29_lista", outv(), V_LISTA);
      repeat (2) @(negedge clk_50Mhz);
      retirar = 1'b1;
      @(negedge clk_50Mhz);
      retirar = 1'b0;
      check("moca_idle_after_retirar", outv(), V_IDLE);
      @(negedge clk_50Mhz);

      // Espresso without sugar; retirar, start while busy and abort in READY all ignored
      expect_run(V_CAFE, 8, 1'b0);
      expect_run(V_AGUA, 4, 1'b1);
      expect_run(V_LISTA, 2, 1'b1);
      issue_start(3'd0, 1'b0);
      check("esp_first_valve", outv(), V_CAFE);
      retirar = 1'b1;
      @(negedge clk_50Mhz);
      retirar = 1'b0;
      start = 1'b1;
      drink = 3'd2;
      @(negedge clk_50Mhz);
      start = 1'b0;
      check("esp_start_while_busy", outv(), V_CAFE);
      repeat (10) @(negedge clk_50Mhz);
      check("esp_c13_lista", outv(), V_LISTA);
      abort = 1'b1;
      @(negedge clk_50Mhz);
      abort = 1'b0;
      check("esp_abort_in_ready", outv(), V_LISTA);
      retirar = 1'b1;
      @(negedge clk_50Mhz);
      retirar = 1'b0;
      check("esp_busy_after_retirar", {7'b0, busy}, 8'h00);
      @(negedge clk_50Mhz);

      // Invalid drink code
      expect_run(V_ERR, 1, 1'b0);
      issue_start(3'd6, 1'b0);
      check("err_pulse", outv(), V_ERR);
      @(negedge clk_50Mhz);
      check("err_one_cycle", outv(), V_IDLE);
      @(negedge clk_50Mhz);

      // Start and abort together: start accepted, abort taken on the next edge
      expect_run(V_CAFE, 1, 1'b0);
      abort = 1'b1;
      issue_start(3'd2, 1'b0);
      check("start_over_abort", outv(), V_CAFE);
      @(negedge clk_50Mhz);
      abort = 1'b0;
      check("abort_next_edge", outv(), V_IDLE);
      @(negedge clk_50Mhz);

      // Latte aborted at cycle 5
      expect_run(V_CAFE, 5, 1'b0);
      issue_start(3'd2, 1'b0);
      repeat (4) @(negedge clk_50Mhz);
      abort = 1'b1;
      @(negedge clk_50Mhz);
      abort = 1'b0;
      check("latte_abort_idle", outv(), V_IDLE);
      repeat (12) @(negedge clk_50Mhz);
      check("latte_no_lista", outv(), V_IDLE);

      // Cappuccino, second start ignored, reset mid-leche
      expect_run(V_CAFE, 8, 1'b0);
      expect_run(V_AGUA, 4, 1'b1);
      expect_run(V_LECHE, 4, 1'b1);
      issue_start(3'd3, 1'b0);
      check("capp_first_valve", outv(), V_CAFE);
      @(negedge clk_50Mhz);
      start = 1'b1;
      drink = 3'd0;
      @(negedge clk_50Mhz);
      start = 1'b0;
      repeat (13) @(negedge clk_50Mhz);
      check("capp_c16_leche", outv(), V_LECHE);
      #2 rst = 1'b0;
      #1 check("capp_leche_async_drop", {7'b0, leche}, 8'h00);
      check("capp_reset_outputs", outv(), V_IDLE);
      @(negedge clk_50Mhz);

      // Start on the very first edge after reset release
      expect_run(V_AZ, 4, 1'b0);
      expect_run(V_CAFE, 8, 1'b1);
      expect_run(V_AGUA, 4, 1'b1);
      expect_run(V_LISTA, 1, 1'b1);
      rst = 1'b1;
      issue_start(3'd0, 1'b1);
      check("post_reset_first_valve", outv(), V_AZ);
      repeat (16) @(negedge clk_50Mhz);
      check("post_reset_c17_lista", outv(), V_LISTA);
      retirar = 1'b1;
      @(negedge clk_50Mhz);
      retirar = 1'b0;
      check("post_reset_idle", outv(), V_IDLE);

      repeat (3) @(negedge clk_50Mhz);
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL runs_outstanding: %0d expected runs never seen, expected 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
